// File: rtl/scp_pkg.sv
// Shared constants for the serial code-path loader: frame sync byte and FSM state encodings.
package scp_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  // States in which the loader still consumes bytes from the stream.
  function automatic logic state_accepts(input logic [2:0] st);
    return (st == ST_IDLE) || (st == ST_COUNT) || (st == ST_DATA) || (st == ST_CHECK);
  endfunction

endpackage

// File: rtl/inst_loader_word_assembler.sv
// Packs an MSB-first byte stream into 32-bit words; word_done flags the cycle the 4th byte arrives.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  // Only the three oldest bytes need storage; the 4th comes straight from the input.
  logic [23:0] shift_reg;
  logic [31:0] shift_next;
  logic [1:0]  cnt_reg;

  assign shift_next[7:0] = byte_data;

  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lane
      assign shift_next[8*gi +: 8] = shift_reg[8*(gi-1) +: 8];
    end
  endgenerate

  assign word      = shift_next;
  assign word_done = byte_valid && (cnt_reg == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (byte_valid) begin
      shift_reg <= shift_next[23:0];
      cnt_reg   <= cnt_reg + 2'd1;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot loader: parses a SYNC/COUNT/DATA/CHECK byte frame, writes words to instruction memory,
// and releases the core from reset only after the XOR checksum matches.
module inst_loader
  import scp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

  localparam int         IDX_W      = $clog2(DEPTH_WORDS + 1);
  localparam logic [7:0] DEPTH_BYTE = 8'(DEPTH_WORDS);

  logic [2:0]       state_reg, state_next;
  logic [IDX_W-1:0] count_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [7:0]       csum_reg;
  logic             mem_we_reg;
  logic [31:0]      mem_addr_reg;
  logic [31:0]      mem_wdata_reg;

  logic        accept;
  logic        data_byte;
  logic        asm_clr;
  logic [31:0] asm_word;
  logic        word_done;
  logic        last_word;

  assign rx_ready  = !rst && state_accepts(state_reg);
  assign accept    = rx_valid && rx_ready;
  assign data_byte = accept && (state_reg == ST_DATA);
  assign asm_clr   = accept && (state_reg == ST_COUNT);
  assign last_word = (idx_reg == count_reg - 1'b1);

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .byte_valid (data_byte),
    .byte_data  (rx_data),
    .word       (asm_word),
    .word_done  (word_done)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept && rx_data == SYNC_BYTE) state_next = ST_COUNT;
      end
      ST_COUNT: begin
        if (accept) begin
          if (rx_data == 8'd0 || rx_data > DEPTH_BYTE) state_next = ST_ERROR;
          else                                         state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_done && last_word) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (accept) state_next = (rx_data == csum_reg) ? ST_DONE : ST_ERROR;
      end
      default: state_next = state_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      count_reg     <= '0;
      idx_reg       <= '0;
      csum_reg      <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= BASE_ADDR;
      mem_wdata_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mem_we_reg <= word_done;
      if (asm_clr) begin
        count_reg <= rx_data[IDX_W-1:0];
        idx_reg   <= '0;
        csum_reg  <= '0;
      end
      if (data_byte) csum_reg <= csum_reg ^ rx_data;
      // Address and data are captured with the strobe so they hold between writes.
      if (word_done) begin
        idx_reg       <= idx_reg + 1'b1;
        mem_addr_reg  <= BASE_ADDR + {{(30-IDX_W){1'b0}}, idx_reg, 2'b00};
        mem_wdata_reg <= asm_word;
      end
    end
  end

  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign core_rst  = (state_reg != ST_DONE);
  assign done      = (state_reg == ST_DONE);
  assign err       = (state_reg == ST_ERROR);

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: expected writes are queued when frames are driven and
// matched against each mem_we pulse, together with pulse width and latency.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frame_q[$];
  wr_t        mon_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last4_cyc = -1;
  int         wr_count = 0;
  logic       prev_we = 1'b0;

  inst_loader #(
    .DEPTH_WORDS (64),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rst  (core_rst),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_count++;
      $display("write %0d addr=%h data=%h cycle=%0d", wr_count, mem_addr, mem_wdata, cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h required=none", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
          errors++;
          $display("FAIL write_value addr=%h data=%h required addr=%h data=%h",
                   mem_addr, mem_wdata, mon_e.addr, mon_e.data);
        end
      end
      checks++;
      if (prev_we !== 1'b0 || cyc != last4_cyc) begin
        errors++;
        $display("FAIL write_timing prev_we=%b cycle=%0d required prev_we=0 cycle=%0d",
                 prev_we, cyc, last4_cyc);
      end
    end
    prev_we = mem_we;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'hA5;
    #1;
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_reset rx_ready=%b required=0", rx_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    rx_valid = 1'b0;
    exp_q.delete();
    wr_count = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit is_last);
    int n;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    #1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout byte=%h rx_ready=%b required=1", b, rx_ready);
      rx_valid = 1'b0;
      return;
    end
    if (is_last) last4_cyc = cyc + 1;
    @(posedge clk);
  endtask

  task automatic send_frame(input int gap, input int off);
    int nw;
    bit last;
    nw = (frame_q.size() > off + 1) ? int'(frame_q[off+1]) : 0;
    for (int i = 0; i < frame_q.size(); i++) begin
      last = (i >= off + 2) && (i < off + 2 + 4*nw) && (((i - off - 2) % 4) == 3);
      send_byte(frame_q[i], gap, last);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic load_std(input logic [7:0] chk);
    frame_q = {8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h08, chk};
  endtask

  task automatic push_std();
    exp_q.push_back('{addr: 32'h0, data: 32'h0000_0020});
    exp_q.push_back('{addr: 32'h4, data: 32'h0000_0008});
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({core_rst, done, err, mem_we, rx_ready} !== 5'b10001) begin
      errors++;
      $display("FAIL reset_flags core_rst/done/err/we/ready=%b required=10001",
               {core_rst, done, err, mem_we, rx_ready});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem addr=%h data=%h required 0/0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_valid_frame(input string name, input int gap, input bit junk);
    do_reset();
    load_std(8'h28);
    if (junk) begin
      frame_q.push_front(8'h5A);
      frame_q.push_front(8'hFF);
      frame_q.push_front(8'h00);
    end
    push_std();
    send_frame(gap, junk ? 3 : 0);
    checks++;
    if ({done, err, core_rst, rx_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL %s_status done/err/core_rst/ready=%b required=1000", name,
               {done, err, core_rst, rx_ready});
    end
    checks++;
    if (wr_count != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_writes count=%0d pending=%0d required 2/0", name, wr_count, exp_q.size());
    end
    checks++;
    if (mem_addr !== 32'h4 || mem_wdata !== 32'h8) begin
      errors++;
      $display("FAIL %s_hold addr=%h data=%h required 4/8", name, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_bad_check();
    do_reset();
    load_std(8'h29);
    push_std();
    send_frame(0, 0);
    checks++;
    if ({done, err, core_rst, rx_ready} !== 4'b0110) begin
      errors++;
      $display("FAIL bad_check_status done/err/core_rst/ready=%b required=0110",
               {done, err, core_rst, rx_ready});
    end
    checks++;
    if (wr_count != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bad_check_writes count=%0d pending=%0d required 2/0", wr_count, exp_q.size());
    end
  endtask

  task automatic test_bad_count(input logic [7:0] n);
    do_reset();
    frame_q = {8'hA5, n};
    send_frame(0, 0);
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if ({done, err, core_rst, rx_ready} !== 4'b0110) begin
      errors++;
      $display("FAIL bad_count_%h_status done/err/core_rst/ready=%b required=0110", n,
               {done, err, core_rst, rx_ready});
    end
    checks++;
    if (wr_count != 0) begin
      errors++;
      $display("FAIL bad_count_%h_writes count=%0d required=0", n, wr_count);
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    frame_q = {8'hA5, 8'h02, 8'h00, 8'h00};
    send_frame(0, 0);
    checks++;
    if (wr_count != 0 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre writes=%0d core_rst=%b required 0/1", wr_count, core_rst);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (core_rst !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_reset core_rst=%b required=1", core_rst);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (core_rst !== 1'b1 || wr_count != 0) begin
      errors++;
      $display("FAIL abort_post core_rst=%b writes=%0d required 1/0", core_rst, wr_count);
    end
    load_std(8'h28);
    push_std();
    send_frame(0, 0);
    checks++;
    if ({done, err, core_rst} !== 3'b100 || wr_count != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_reload done/err/core_rst=%b writes=%0d pending=%0d required 100/2/0",
               {done, err, core_rst}, wr_count, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame("back_to_back", 0, 1'b0);
    test_bad_check();
    test_bad_count(8'h00);
    test_bad_count(8'h41);
    test_valid_frame("leading_junk", 0, 1'b1);
    test_valid_frame("gaps", 2, 1'b0);
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $fatal(1, "bench timeout");
  end

endmodule
